// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter owning the select of a shared 4-to-1 data mux
module mux4_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    output logic [3:0]        grant,
    output logic [1:0]        sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            st_q, st_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [2:0]        win_idle;
    logic [2:0]        win_next;
    logic [1:0]        next_ptr;
    logic              tenure_end;

    // Returns {found, index}: first requester at or after p, wrapping mod 4.
    function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Handover rotates priority past the current owner before re-arbitrating.
    assign next_ptr   = sel_q + 2'd1;
    assign win_idle   = arbitrate(req, ptr_q);
    assign win_next   = arbitrate(req, next_ptr);
    assign tenure_end = !req[sel_q] || (hold_q == HOLD_LAST);

    // State register; reset clears any tenure in progress without completing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            sel_q  <= 2'd0;
            ptr_q  <= 2'd0;
            hold_q <= '0;
        end else begin
            st_q   <= st_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
            hold_q <= hold_d;
        end
    end

    // Next-state: start a tenure from idle, or extend/hand over an active one with no idle bubble.
    always_comb begin
        st_d   = st_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        hold_d = hold_q;
        case (st_q)
            ST_IDLE: begin
                if (win_idle[2]) begin
                    st_d   = ST_GRANT;
                    sel_d  = win_idle[1:0];
                    hold_d = '0;
                end
            end
            ST_GRANT: begin
                if (tenure_end) begin
                    ptr_d  = next_ptr;
                    hold_d = '0;
                    if (win_next[2]) begin
                        sel_d = win_next[1:0];
                    end else begin
                        st_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: data path is purely combinational from the registered select.
    always_comb begin
        grant    = 4'b0000;
        out_data = '0;
        if (st_q == ST_GRANT) begin
            grant[sel_q] = 1'b1;
            case (sel_q)
                2'd0:    out_data = data0;
                2'd1:    out_data = data1;
                2'd2:    out_data = data2;
                default: out_data = data3;
            endcase
        end
    end

    assign sel       = sel_q;
    assign out_valid = (st_q == ST_GRANT);
    assign busy      = (st_q == ST_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;

    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        req = 4'b0000;
    logic [DATA_W-1:0] dv [4];
    logic [3:0]        grant;
    logic [1:0]        sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 idle), rotating priority, cycles spent in tenure.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_len   = 0;
    int m_sel   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data0     (dv[0]),
        .data1     (dv[1]),
        .data2     (dv[2]),
        .data3     (dv[3]),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_grant();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data();
        return (m_owner >= 0) ? dv[m_owner] : '0;
    endfunction

    task automatic tick();
        int w;
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_len = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin m_owner = w; m_sel = w; m_len = 1; end
        end else if (!req[m_owner] || m_len == MAX_HOLD) begin
            m_ptr = (m_owner + 1) % 4;
            w = pick(req, m_ptr);
            if (w >= 0) begin m_owner = w; m_sel = w; m_len = 1; end
            else m_owner = -1;
        end else begin
            m_len++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111;
        for (int i = 0; i < 4; i++) dv[i] = 8'h10 + 8'(i);
        tick(); tick();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b/%b exp=0/0", out_valid, busy); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", out_data); end
        rst = 1'b0;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_release got=%b exp=0001", grant); end
    endtask

    task automatic test_single();
        do_reset();
        dv[2] = 8'hA5; req = 4'b0100;
        tick();
        checks++; if (grant !== 4'b0100 || sel !== 2'd2 || out_data !== 8'hA5)
            begin errors++; $display("FAIL single_grant got=%b/%0d/%h exp=0100/2/a5", grant, sel, out_data); end
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (grant !== 4'b0100 || out_valid !== 1'b1)
                begin errors++; $display("FAIL single_hold cyc=%0d got=%b exp=0100", c, grant); end
        end
        req = 4'b0000;
        tick();
        checks++; if (grant !== 4'b0000 || out_data !== 8'h00)
            begin errors++; $display("FAIL single_drop got=%b/%h exp=0000/00", grant, out_data); end
    endtask

    task automatic test_fairness();
        logic [3:0] e;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            e = 4'b0000;
            e[(c / MAX_HOLD) % 4] = 1'b1;
            checks++; if (grant !== e)
                begin errors++; $display("FAIL fair cyc=%0d got=%b exp=%b", c, grant, e); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100; tick();
        req = 4'b0000; tick();
        req = 4'b1001; tick();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_grant3 got=%b exp=1000", grant); end
        tick();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_hold3 got=%b exp=1000", grant); end
        req = 4'b0001; tick();
        checks++; if (grant !== 4'b0001 || sel !== 2'd0)
            begin errors++; $display("FAIL wrap_to0 got=%b/%0d exp=0001/0", grant, sel); end
        checks++; if (m_ptr !== 0 || grant !== exp_grant())
            begin errors++; $display("FAIL wrap_model got=%b exp=%b", grant, exp_grant()); end
    endtask

    task automatic test_passthrough();
        do_reset();
        dv[1] = 8'h11; req = 4'b0010;
        tick();
        checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL pass_initial got=%h exp=11", out_data); end
        #2 dv[1] = 8'h22; #1;
        checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL pass_follow got=%h exp=22", out_data); end
        dv[0] = 8'h5A; dv[2] = 8'hC3; dv[3] = 8'h3C; #1;
        checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL pass_isolate got=%h exp=22", out_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick(); tick(); tick();
        rst = 1'b1; tick();
        checks++; if (grant !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL midrst_clear got=%b/%0d/%b exp=0000/0/0", grant, sel, out_valid); end
        rst = 1'b0; tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL midrst_restart got=%b exp=0010", grant); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
            for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            checks++; if (grant !== exp_grant())
                begin errors++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, grant, exp_grant()); end
            checks++; if (sel !== 2'(m_sel))
                begin errors++; $display("FAIL rand_sel cyc=%0d got=%0d exp=%0d", c, sel, m_sel); end
            checks++; if (out_valid !== (m_owner >= 0) || busy !== (m_owner >= 0))
                begin errors++; $display("FAIL rand_valid cyc=%0d got=%b/%b exp=%0d", c, out_valid, busy, m_owner >= 0); end
            checks++; if (out_data !== exp_data())
                begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, out_data, exp_data()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dv[i] = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_passthrough();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4-to-1 multiplexer between four requesters. Each requester raises a request line; the block grants exactly one at a time, drives the mux select, and presents the granted requester's data on a single output bus. Tenure is bounded so no requester can starve the others. It sits in front of the shared Decoder/MUX datapath and is the only block that drives its select lines.

## Interface
- DATA_W, 8, width of each requester data bus and of the output
- MAX_HOLD, 4, maximum consecutive cycles one grant tenure may last (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req  in  4  request lines; req[i] is requester i
- data0..data3  in  DATA_W each  requester data
- grant  out  4  one-hot grant, all-zero when idle
- sel  out  2  mux select, index of granted requester
- out_valid  out  1  high while any grant is active
- out_data  out  DATA_W  data of the granted requester, 0 when idle
- busy  out  1  equals out_valid (compatibility strobe)

One clock. Reset is synchronous and active-high.

## Operation
- Registered state: st ∈ {IDLE, GRANT}, sel[1:0], ptr[1:0] (highest-priority index), hold_cnt (0..MAX_HOLD-1).
- Arbitration function: first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
- IDLE: if any req, then at the next edge st=GRANT, sel=winner, hold_cnt=0. Otherwise stay IDLE.
- GRANT: tenure ends at an edge where req[sel]=0 or hold_cnt=MAX_HOLD-1. Otherwise hold_cnt increments.
- On tenure end: ptr←sel+1 mod 4, and arbitration is run with that new ptr in the same cycle.
  - If any req is pending, st stays GRANT with the new winner and hold_cnt←0. There is no idle bubble.
  - If none is pending, st←IDLE.
- A requester still requesting at tenure end is re-granted only if no other requester is pending. Its new tenure starts with hold_cnt=0.
- grant = (st==GRANT) ? onehot(sel) : 0.
- out_valid = busy = (st==GRANT).
- out_data = (st==GRANT) ? data[sel] : 0. The data path is combinational from registered sel, so data changes pass through with zero latency.
- The req inputs are sampled only at edges. Glitches between edges are ignored.

## Timing
- Reset values: st=IDLE, sel=0, ptr=0, hold_cnt=0, grant=0000, out_valid=0, busy=0, out_data=0.
- Reset has priority over every other event. Asserting rst mid-tenure clears all state at that edge, with no completion of the tenure.
- Latency: req[i] sampled high at edge k while IDLE → grant[i]=1 after edge k.
- Release latency: req[sel] sampled low at edge k → grant drops (or moves to the next winner) after edge k. The granted output is therefore visible for the cycle in which req fell.
- Maximum tenure: exactly MAX_HOLD cycles. With MAX_HOLD=1, the grant rotates every cycle among active requesters.
- Back-to-back handover: grant changes from one-hot A to one-hot B in a single edge, and grant is never all-zero in between.
- ptr wraps 3→0.
- Simultaneous requests are resolved by the arbitration function only. There is no fixed priority beyond ptr.
- A new request from another requester during a tenure does not pre-empt that tenure.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=1111 → grant=0000, sel=0, out_valid=0, out_data=0. After release, grant=0001 one edge later.
- Single request: req=0100, data2=8'hA5 → grant=0100, sel=2, out_data=A5.
  - Holding req for 10 cycles gives tenures of 4 cycles each, re-granted to 2 with no gap.
  - Dropping req gives grant=0000 after the edge where it is sampled low.
- Round-robin fairness: req=1111 continuously, MAX_HOLD=4 → grant sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001… (each transition occurs in a single edge).
- Early release and wrap: ptr=3 state, req=1001 → requester 3 is granted. Drop req[3] after 2 cycles → grant=0001 at the next edge, and ptr becomes 0 after that tenure.
- Mux pass-through: while sel=1 is granted, change data1 from 8'h11 to 8'h22 mid-cycle → out_data follows in the same cycle. data0/2/3 changes produce no effect.
- Reset mid-tenure: assert rst at hold_cnt=2 with req=0010 → everything clears. After rst drops, arbitration restarts from ptr=0 and grant=0010 after one edge.
